issue_select: RTL and testbench

- Requester-facing end of the issue-queue handshake: watches every slot's request/priority, grants at most one slot per cycle, and captures the granted slot's read bus into a one-entry issue register toward the execution unit.
- Sits between the issue-queue slot array and the functional-unit pipeline.
- Applies branch-kill to the captured micro-op and provides backpressure via the FU ready signal.

---
 rtl/issue_select.sv | 82 ++++++++
 tb/tb_issue_select.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Issue-select stage: picks one requesting slot per cycle (highest priority wins) and latches its uop into a one-entry issue register.
// Optional ISSUE_SELECT_RR_EN breaks equal-priority ties round-robin instead of by lowest slot index.
module issue_select #(
   parameter int NUM_SLOTS = 8,
   parameter int WIDTH_REG = 5,
   parameter int WIDTH_TAG = 5,
   parameter int WIDTH_BRM = 3,
   parameter int WIDTH_PRY = 2,
   parameter int WIDTH_O   = WIDTH_BRM + WIDTH_TAG + 2 + 3*WIDTH_REG
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_SLOTS-1:0]           i_request,
   input  logic [NUM_SLOTS*WIDTH_PRY-1:0] i_priority,
   output logic [NUM_SLOTS-1:0]           o_grant,
   input  logic [WIDTH_O-1:0]             i_rslot,
   input  logic [2**WIDTH_BRM-1:0]        i_brkill,
   input  logic                           i_ready,
   output logic                           o_valid,
   output logic [WIDTH_O-1:0]             o_uop
);
   localparam int IDX_W   = $clog2(NUM_SLOTS);
   localparam int BRM_MSB = WIDTH_O - 1;

   logic [NUM_SLOTS-1:0][WIDTH_PRY-1:0] pri;
   logic                 can_issue, grant_any, kill_in, kill_held;
   logic [IDX_W-1:0]     grant_idx, start;
   logic [WIDTH_PRY-1:0] best_pri;
   logic [IDX_W-1:0]     k;

   assign pri       = i_priority;
   assign can_issue = ~o_valid | i_ready;
   assign kill_in   = i_brkill[i_rslot[BRM_MSB -: WIDTH_BRM]];
   assign kill_held = i_brkill[o_uop[BRM_MSB -: WIDTH_BRM]];

`ifdef ISSUE_SELECT_RR_EN
   logic [IDX_W-1:0] rr_ptr;
   assign start = rr_ptr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)          rr_ptr <= '0;
      else if (grant_any) rr_ptr <= grant_idx + IDX_W'(1);  // power-of-two slots: wrap is free
   end
`else
   assign start = '0;
`endif

   // Scan slots in order from start; strict '>' keeps the first slot seen among equals.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      best_pri  = '0;
      k         = '0;
      for (int j = 0; j < NUM_SLOTS; j++) begin
         k = start + IDX_W'(j);
         if (i_request[k] && (!grant_any || pri[k] > best_pri)) begin
            grant_any = 1'b1;
            grant_idx = k;
            best_pri  = pri[k];
         end
      end
      grant_any = grant_any & can_issue & ~i_rst;
   end

   always_comb begin
      o_grant = '0;
      if (grant_any) o_grant[grant_idx] = 1'b1;
   end

   // A new grant overwrites the held uop even if it is being killed this cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_uop   <= '0;
      end else if (grant_any) begin
         o_uop   <= i_rslot;
         o_valid <= ~kill_in;
      end else if (o_valid && (i_ready || kill_held)) begin
         o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: grants checked inline, accepted uops checked through a scoreboard queue.
module tb_issue_select;
   localparam int N  = 8;
   localparam int WO = 25;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [N-1:0]  i_request = '0;
   logic [15:0]   i_priority = '0;
   logic [N-1:0]  o_grant;
   logic [WO-1:0] i_rslot = '0;
   logic [7:0]    i_brkill = '0;
   logic          i_ready = 1'b0;
   logic          o_valid;
   logic [WO-1:0] o_uop;

   int n_cmp = 0;
   int n_bad = 0;
   logic [WO-1:0] sb_q[$];

   issue_select dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_request(i_request), .i_priority(i_priority),
      .o_grant(o_grant), .i_rslot(i_rslot), .i_brkill(i_brkill), .i_ready(i_ready),
      .o_valid(o_valid), .o_uop(o_uop)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [WO-1:0] mk(input int brm, input int n);
      logic [2:0] b; logic [4:0] t, rd, r2, r1; logic [1:0] bk;
      b = 3'(brm); t = 5'(n); bk = 2'(n); rd = 5'(n + 3); r2 = 5'(n + 7); r1 = 5'(n + 11);
      return {b, t, bk, rd, r2, r1};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, then wait to mid-cycle.
   task automatic drive(input logic [N-1:0] req, input logic [15:0] pr, input logic [WO-1:0] rs,
                        input logic [7:0] bk, input logic rdy);
      @(posedge i_clk); #1;
      i_request = req; i_priority = pr; i_rslot = rs; i_brkill = bk; i_ready = rdy;
      @(negedge i_clk);
   endtask

   // Monitor: every uop the FU accepts (and is not being killed) must match the next queued one.
   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready && !i_brkill[o_uop[WO-1 -: 3]]) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_accept: got %h expected none (queue empty)", o_uop);
         end else begin
            logic [WO-1:0] e;
            e = sb_q.pop_front();
            if (o_uop !== e) begin
               n_bad++;
               $display("FAIL sb_accept: got %h expected %h", o_uop, e);
            end
         end
      end
   end

   initial begin
      logic [WO-1:0] u;
      logic [N-1:0] g;
      // reset state, requests present but grant gated
      i_request = 8'hFF;
      @(negedge i_clk);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_uop", 32'(o_uop), 0);
      chk("rst_grant", 32'(o_grant), 0);
      @(posedge i_clk); #1; i_rst = 1'b0; i_request = '0;

      // max priority: slot5 (3) beats slot2 (1)
      u = mk(0, 1); sb_q.push_back(u);
      drive(8'b0010_0100, 16'h0C10, u, 8'h00, 1'b1);
      chk("pri_grant", 32'(o_grant), 32'h20);
      drive('0, '0, '0, 8'h00, 1'b1);
      chk("lat_valid", 32'(o_valid), 1);
      chk("lat_uop", 32'(o_uop), 32'(mk(0, 1)));
      chk("idle_grant", 32'(o_grant), 0);

      // equal priority 2 on slots 1 and 6, back-to-back
      for (int c = 0; c < 4; c++) begin
`ifdef ISSUE_SELECT_RR_EN
         g = (c % 2 == 0) ? 8'h40 : 8'h02;
`else
         g = 8'h02;
`endif
         u = mk(0, 3 + c); sb_q.push_back(u);
         drive(8'b0100_0010, 16'h2008, u, 8'h00, 1'b1);
         chk("tie_grant", 32'(o_grant), 32'(g));
      end

      // full: no grant, hold contents
      for (int c = 0; c < 2; c++) begin
         drive(8'hFF, 16'h0000, mk(0, 20), 8'h00, 1'b0);
         chk("full_grant", 32'(o_grant), 0);
         chk("full_valid", 32'(o_valid), 1);
         chk("full_uop", 32'(o_uop), 32'(mk(0, 6)));
      end
      // ready back: grant in same cycle
`ifdef ISSUE_SELECT_RR_EN
      g = 8'h04;
`else
      g = 8'h01;
`endif
      u = mk(0, 9); sb_q.push_back(u);
      drive(8'hFF, 16'h0000, u, 8'h00, 1'b1);
      chk("resume_grant", 32'(o_grant), 32'(g));

      // grant of a uop killed on arrival
      drive(8'b0000_1000, '0, mk(3, 10), 8'b0000_1000, 1'b1);
      chk("killin_grant", 32'(o_grant), 32'h08);
      drive('0, '0, '0, 8'h00, 1'b1);
      chk("killin_valid", 32'(o_valid), 0);

      // kill of a held uop while stalled
      drive(8'h01, '0, mk(5, 12), 8'h00, 1'b1);
      chk("load12_grant", 32'(o_grant), 32'h01);
      drive('0, '0, '0, 8'b0010_0000, 1'b0);
      chk("held_valid", 32'(o_valid), 1);
      chk("held_uop", 32'(o_uop), 32'(mk(5, 12)));
      drive('0, '0, '0, 8'h00, 1'b0);
      chk("killheld_valid", 32'(o_valid), 0);

      // kill of held uop plus a new unkilled grant in the same cycle
      drive(8'h01, '0, mk(5, 15), 8'h00, 1'b1);
      chk("load15_grant", 32'(o_grant), 32'h01);
      u = mk(1, 16); sb_q.push_back(u);
      drive(8'h04, '0, u, 8'b0010_0000, 1'b1);
      chk("killgrant_grant", 32'(o_grant), 32'h04);
      drive('0, '0, '0, 8'h00, 1'b1);
      chk("killgrant_valid", 32'(o_valid), 1);
      chk("killgrant_uop", 32'(o_uop), 32'(mk(1, 16)));

      // async reset mid-stream
      drive(8'h10, '0, mk(2, 18), 8'h00, 1'b1);
      chk("load18_grant", 32'(o_grant), 32'h10);
      drive(8'hFF, '0, mk(0, 19), 8'h00, 1'b0);
      chk("prerst_valid", 32'(o_valid), 1);
      #2 i_rst = 1'b1;
      #1;
      chk("asyncrst_valid", 32'(o_valid), 0);
      i_ready = 1'b1;
      #1;
      chk("asyncrst_grant", 32'(o_grant), 0);
      @(posedge i_clk); #1; i_rst = 1'b0; i_request = '0;
      @(negedge i_clk);
      chk("post_valid", 32'(o_valid), 0);
      chk("sb_drained", 32'(sb_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
